// File: rtl/transition_controller_pkg.sv
// Shared types and constants for the stage-transition controller.
//   state_t   : iris sequencing states (OPENING, BRIGHT, CLOSING, DARK)
//   MASK_ON   : mask value for a visible pixel
//   MASK_OFF  : mask value for a black pixel
//   COL_W/ROW_W/RAD_W : pixel column, pixel row and radius widths
package transition_controller_pkg;

  typedef enum logic [1:0] {
    OPENING = 2'd0,
    BRIGHT  = 2'd1,
    CLOSING = 2'd2,
    DARK    = 2'd3
  } state_t;

  localparam logic [11:0] MASK_ON  = 12'hFFF;
  localparam logic [11:0] MASK_OFF = 12'h000;

  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int RAD_W = 10;

endpackage

// File: rtl/iris_mask_pipe.sv
// Two-stage iris mask datapath.
// Stage 1 registers dx^2, dy^2, r^2 and the controller state.
// Stage 2 registers the inclusive circle compare, or the BRIGHT/DARK override.
// Ports:
//   clk, rstn          : pixel clock, async active-low reset
//   col_addr, row_addr : current pixel
//   cx, cy             : iris centre
//   radius             : current iris radius
//   state              : controller state, aligned with the pixel it is sampled with
//   mask               : 12'hFFF visible / 12'h000 black, 2 cycles after the address
module iris_mask_pipe
  import transition_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [COL_W-1:0] col_addr,
  input  logic [ROW_W-1:0] row_addr,
  input  logic [COL_W-1:0] cx,
  input  logic [ROW_W-1:0] cy,
  input  logic [RAD_W-1:0] radius,
  input  state_t           state,
  output logic [11:0]      mask
);

  logic signed [10:0] dx_s;
  logic signed [10:0] dy_s;
  logic [9:0]         abs_dx_s;
  logic [9:0]         abs_dy_s;
  logic [20:0]        dx_sq_s;
  logic [20:0]        dy_sq_s;
  logic [19:0]        r_sq_s;
  logic [20:0]        dx_sq_r;
  logic [20:0]        dy_sq_r;
  logic [19:0]        r_sq_r;
  state_t             state_s1_r;
  logic [21:0]        dist_sq_s;
  logic [11:0]        mask_nxt_s;
  logic [11:0]        mask_r;

  // Signed offsets and their squares; magnitudes always fit 10 bits, so squares are exact.
  always_comb begin
    dx_s     = $signed({1'b0, col_addr}) - $signed({1'b0, cx});
    dy_s     = $signed({2'b00, row_addr}) - $signed({2'b00, cy});
    abs_dx_s = dx_s[10] ? 10'(-dx_s) : 10'(dx_s);
    abs_dy_s = dy_s[10] ? 10'(-dy_s) : 10'(dy_s);
    dx_sq_s  = 21'(abs_dx_s) * 21'(abs_dx_s);
    dy_sq_s  = 21'(abs_dy_s) * 21'(abs_dy_s);
    r_sq_s   = 20'(radius) * 20'(radius);
  end

  // Stage 1: squares and state. State resets to DARK so the first mask out of reset is black.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dx_sq_r    <= 21'd0;
      dy_sq_r    <= 21'd0;
      r_sq_r     <= 20'd0;
      state_s1_r <= DARK;
    end else begin
      dx_sq_r    <= dx_sq_s;
      dy_sq_r    <= dy_sq_s;
      r_sq_r     <= r_sq_s;
      state_s1_r <= state;
    end
  end

  // Inclusive circle test with state override taken from the same pipeline slot.
  always_comb begin
    dist_sq_s  = 22'(dx_sq_r) + 22'(dy_sq_r);
    mask_nxt_s = MASK_OFF;
    case (state_s1_r)
      BRIGHT:  mask_nxt_s = MASK_ON;
      DARK:    mask_nxt_s = MASK_OFF;
      default: begin
        if (dist_sq_s <= 22'(r_sq_r)) begin
          mask_nxt_s = MASK_ON;
        end else begin
          mask_nxt_s = MASK_OFF;
        end
      end
    endcase
  end

  // Stage 2: registered mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_r <= MASK_OFF;
    end else begin
      mask_r <= mask_nxt_s;
    end
  end

  assign mask = mask_r;

endmodule

// File: rtl/transition_controller.sv
// Stage-transition controller: sequences the iris OPENING -> BRIGHT -> CLOSING -> DARK,
// tracks the stage index and pulses the game-core reset while the screen is dark.
// Ports:
//   clk, rstn          : pixel clock, async active-low reset
//   frame_tick         : one-cycle pulse per frame
//   over               : [1] event valid, [0] win(1)/lose(0); only honoured in BRIGHT
//   cx, cy             : iris centre
//   col_addr, row_addr : current pixel
//   mask               : per-pixel mask, 2 cycles after the address
//   stage              : current stage index
//   game_rstn          : active-low reset pulse to the game core
//   busy               : low only in BRIGHT
module transition_controller
  import transition_controller_pkg::*;
#(
  parameter int MAX_RADIUS  = 640,
  parameter int RADIUS_STEP = 1,
  parameter int DARK_FRAMES = 30,
  parameter int RESET_TICKS = 8,
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_W     = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic [1:0]         over,
  input  logic [COL_W-1:0]   cx,
  input  logic [ROW_W-1:0]   cy,
  input  logic [COL_W-1:0]   col_addr,
  input  logic [ROW_W-1:0]   row_addr,
  output logic [11:0]        mask,
  output logic [STAGE_W-1:0] stage,
  output logic               game_rstn,
  output logic               busy
);

  localparam int                 RAD_XW     = RAD_W + 1;
  localparam logic [RAD_W-1:0]   RAD_MAX    = RAD_W'(MAX_RADIUS);
  localparam logic [RAD_XW-1:0]  STEP_EXT   = RAD_XW'(RADIUS_STEP);
  localparam logic [15:0]        DARK_LAST  = 16'(DARK_FRAMES - 1);
  localparam logic [15:0]        RST_LAST   = 16'(RESET_TICKS - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam bit                 DARK_SKIP  = (DARK_FRAMES == 32'sd0);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [RAD_W-1:0]   radius_r;
  logic [RAD_W-1:0]   radius_nxt_s;
  logic [RAD_XW-1:0]  rad_up_s;
  logic [STAGE_W-1:0] stage_r;
  logic [STAGE_W-1:0] stage_nxt_s;
  logic               win_r;
  logic               win_nxt_s;
  logic [15:0]        dark_cnt_r;
  logic [15:0]        dark_cnt_nxt_s;
  logic               pulse_start_s;
  logic [15:0]        rst_cnt_r;
  logic               game_rstn_r;
  logic               busy_r;

  // Next-state, radius, stage and dark-counter logic.
  always_comb begin
    state_nxt_s    = state_r;
    radius_nxt_s   = radius_r;
    stage_nxt_s    = stage_r;
    win_nxt_s      = win_r;
    dark_cnt_nxt_s = dark_cnt_r;
    pulse_start_s  = 1'b0;
    rad_up_s       = {1'b0, radius_r} + STEP_EXT;

    case (state_r)
      OPENING: begin
        if (radius_r == RAD_MAX) begin
          state_nxt_s = BRIGHT;
        end else begin
          state_nxt_s = OPENING;
        end
        if (frame_tick) begin
          if (rad_up_s >= {1'b0, RAD_MAX}) begin
            radius_nxt_s = RAD_MAX;
          end else begin
            radius_nxt_s = rad_up_s[RAD_W-1:0];
          end
        end else begin
          radius_nxt_s = radius_r;
        end
      end

      BRIGHT: begin
        // Radius is deliberately left untouched here, even on a frame tick.
        if (over[1]) begin
          win_nxt_s   = over[0];
          state_nxt_s = CLOSING;
        end else begin
          state_nxt_s = BRIGHT;
        end
      end

      CLOSING: begin
        if (radius_r == {RAD_W{1'b0}}) begin
          state_nxt_s    = DARK;
          dark_cnt_nxt_s = 16'd0;
          pulse_start_s  = 1'b1;
          if (win_r) begin
            if (stage_r == STAGE_LAST) begin
              stage_nxt_s = {STAGE_W{1'b0}};
            end else begin
              stage_nxt_s = stage_r + STAGE_W'(1);
            end
          end else begin
            stage_nxt_s = stage_r;
          end
        end else if (frame_tick) begin
          if ({1'b0, radius_r} > STEP_EXT) begin
            radius_nxt_s = radius_r - STEP_EXT[RAD_W-1:0];
          end else begin
            radius_nxt_s = {RAD_W{1'b0}};
          end
        end else begin
          radius_nxt_s = radius_r;
        end
      end

      DARK: begin
        if (DARK_SKIP) begin
          state_nxt_s = OPENING;
        end else if (frame_tick) begin
          if (dark_cnt_r == DARK_LAST) begin
            state_nxt_s    = OPENING;
            dark_cnt_nxt_s = 16'd0;
          end else begin
            dark_cnt_nxt_s = dark_cnt_r + 16'd1;
          end
        end else begin
          dark_cnt_nxt_s = dark_cnt_r;
        end
      end

      default: begin
        state_nxt_s = OPENING;
      end
    endcase
  end

  // FSM state, radius, stage, win flag, dark counter and busy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= OPENING;
      radius_r   <= {RAD_W{1'b0}};
      stage_r    <= {STAGE_W{1'b0}};
      win_r      <= 1'b0;
      dark_cnt_r <= 16'd0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      radius_r   <= radius_nxt_s;
      stage_r    <= stage_nxt_s;
      win_r      <= win_nxt_s;
      dark_cnt_r <= dark_cnt_nxt_s;
      busy_r     <= (state_nxt_s != BRIGHT);
    end
  end

  // Game reset pulse: low for RESET_TICKS cycles after rstn release or after entering DARK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      game_rstn_r <= 1'b0;
      rst_cnt_r   <= 16'd0;
    end else if (pulse_start_s) begin
      game_rstn_r <= 1'b0;
      rst_cnt_r   <= 16'd0;
    end else if (!game_rstn_r) begin
      if (rst_cnt_r == RST_LAST) begin
        game_rstn_r <= 1'b1;
        rst_cnt_r   <= 16'd0;
      end else begin
        rst_cnt_r   <= rst_cnt_r + 16'd1;
      end
    end else begin
      game_rstn_r <= 1'b1;
      rst_cnt_r   <= rst_cnt_r;
    end
  end

  iris_mask_pipe u_mask (
    .clk      (clk),
    .rstn     (rstn),
    .col_addr (col_addr),
    .row_addr (row_addr),
    .cx       (cx),
    .cy       (cy),
    .radius   (radius_r),
    .state    (state_r),
    .mask     (mask)
  );

  assign stage     = stage_r;
  assign game_rstn = game_rstn_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_transition_controller.sv
// Self-checking bench for transition_controller with a behavioural reference model.
module tb_transition_controller;

  localparam int MAXR  = 10;
  localparam int STEP  = 3;
  localparam int DARKF = 3;
  localparam int RSTT  = 8;
  localparam int NS    = 4;
  localparam int SW    = 2;

  localparam int PH_OPEN   = 0;
  localparam int PH_BRIGHT = 1;
  localparam int PH_CLOSE  = 2;
  localparam int PH_DARK   = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          frame_tick = 1'b0;
  logic [1:0]    over = 2'b00;
  logic [9:0]    cx = 10'd0;
  logic [8:0]    cy = 9'd0;
  logic [9:0]    col_addr = 10'd0;
  logic [8:0]    row_addr = 9'd0;
  logic [11:0]   mask;
  logic [SW-1:0] stage;
  logic          game_rstn;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model
  int          m_phase;
  int          m_r;
  int          m_stage;
  int          m_win;
  int          m_dark;
  int          m_rst_left;
  logic [11:0] m_mask;
  logic [11:0] m_pipe;

  always #5 clk = ~clk;

  transition_controller #(
    .MAX_RADIUS  (MAXR),
    .RADIUS_STEP (STEP),
    .DARK_FRAMES (DARKF),
    .RESET_TICKS (RSTT),
    .NUM_STAGES  (NS),
    .STAGE_W     (SW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .frame_tick (frame_tick),
    .over       (over),
    .cx         (cx),
    .cy         (cy),
    .col_addr   (col_addr),
    .row_addr   (row_addr),
    .mask       (mask),
    .stage      (stage),
    .game_rstn  (game_rstn),
    .busy       (busy)
  );

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_circle(int c, int r, int ccx, int ccy, int rad);
    int dx;
    int dy;
    dx = c - ccx;
    dy = r - ccy;
    return (dx * dx + dy * dy) <= (rad * rad);
  endfunction

  task automatic model_reset();
    m_phase    = PH_OPEN;
    m_r        = 0;
    m_stage    = 0;
    m_win      = 0;
    m_dark     = 0;
    m_rst_left = RSTT;
    m_mask     = 12'h000;
    m_pipe     = 12'h000;
  endtask

  // Advance the model by one clock edge using the inputs that were stable before it.
  task automatic model_step();
    logic [11:0] v;
    int nxt;
    if (!rstn) begin
      model_reset();
    end else begin
      if (m_phase == PH_BRIGHT) v = 12'hFFF;
      else if (m_phase == PH_DARK) v = 12'h000;
      else v = in_circle(int'(col_addr), int'(row_addr), int'(cx), int'(cy), m_r) ? 12'hFFF : 12'h000;
      m_mask = m_pipe;
      m_pipe = v;
      if (m_rst_left > 0) m_rst_left--;
      nxt = m_phase;
      if (m_phase == PH_OPEN) begin
        if (m_r == MAXR) nxt = PH_BRIGHT;
        if (frame_tick) m_r = (m_r + STEP > MAXR) ? MAXR : m_r + STEP;
      end else if (m_phase == PH_BRIGHT) begin
        if (over[1]) begin
          m_win = int'(over[0]);
          nxt = PH_CLOSE;
        end
      end else if (m_phase == PH_CLOSE) begin
        if (m_r == 0) begin
          nxt = PH_DARK;
          if (m_win != 0) m_stage = (m_stage + 1) % NS;
          m_rst_left = RSTT;
          m_dark = 0;
        end else if (frame_tick) begin
          m_r = (m_r > STEP) ? m_r - STEP : 0;
        end
      end else begin
        if (frame_tick) begin
          m_dark++;
          if (m_dark == DARKF) begin
            nxt = PH_OPEN;
            m_dark = 0;
          end
        end
      end
      m_phase = nxt;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mask", int'(mask), int'(m_mask));
      check("stage", int'(stage), m_stage);
      check("game_rstn", int'(game_rstn), (m_rst_left == 0) ? 1 : 0);
      check("busy", int'(busy), (m_phase != PH_BRIGHT) ? 1 : 0);
    end
  end

  task automatic cyc(bit ft, logic [1:0] ov, logic [9:0] c, logic [8:0] r,
                     logic [9:0] ccx, logic [8:0] ccy);
    frame_tick = ft;
    over       = ov;
    col_addr   = c;
    row_addr   = r;
    cx         = ccx;
    cy         = ccy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc_rand(bit ft, logic [1:0] ov, logic [9:0] ccx, logic [8:0] ccy);
    logic [9:0] c;
    logic [8:0] r;
    if ($urandom_range(0, 3) == 0) begin
      c = 10'($urandom_range(0, 1023));
      r = 9'($urandom_range(0, 511));
    end else begin
      c = ccx + 10'($urandom_range(0, 24)) - 10'd12;
      r = ccy + 9'($urandom_range(0, 24)) - 9'd12;
    end
    cyc(ft, ov, c, r, ccx, ccy);
  endtask

  task automatic probe(string nm, logic [9:0] c, logic [8:0] r, logic [11:0] exp);
    cyc(1'b0, 2'b00, c, r, 10'd100, 9'd100);
    cyc(1'b0, 2'b00, c, r, 10'd100, 9'd100);
    check(nm, int'(mask), int'(exp));
  endtask

  // One win/lose event from BRIGHT through close, dark and reopen.
  task automatic do_event(bit win, int exp_stage, bit glitch, bit pulse_chk);
    cyc(1'b0, {1'b1, win}, 10'd100, 9'd100, 10'd100, 9'd100);
    for (int i = 0; i < 200; i++) begin
      if (m_phase == PH_DARK) break;
      cyc_rand(1'($urandom_range(0, 1)), (glitch && i == 1) ? 2'b11 : 2'b00, 10'd100, 9'd100);
    end
    check("stage_at_dark", int'(stage), exp_stage);
    if (pulse_chk) begin
      check("pulse_fall", int'(game_rstn), 0);
      repeat (7) cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
      check("pulse_low7", int'(game_rstn), 0);
      cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
      check("pulse_rise8", int'(game_rstn), 1);
    end
    for (int i = 0; i < 400; i++) begin
      if (busy == 1'b0) break;
      cyc_rand(1'($urandom_range(0, 1)), 2'b00, 10'd100, 9'd100);
    end
    check("reopen_bright", int'(busy), 0);
  endtask

  initial begin
    logic [9:0] rcx;
    logic [8:0] rcy;
    model_reset();
    chk_en = 1'b1;
    repeat (3) cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    check("rst_mask", int'(mask), 12'h000);
    check("rst_grstn", int'(game_rstn), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_stage", int'(stage), 0);

    rstn = 1'b1;
    repeat (7) cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    check("rel_low7", int'(game_rstn), 0);
    cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    check("rel_high8", int'(game_rstn), 1);

    // opening radius 3, 6, 9, 10 with inclusive boundaries
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    probe("r3_edge_in", 10'd103, 9'd100, 12'hFFF);
    probe("r3_edge_out", 10'd104, 9'd100, 12'h000);
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    probe("r6_neg_in", 10'd94, 9'd100, 12'hFFF);
    probe("r6_neg_out", 10'd93, 9'd100, 12'h000);
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    probe("r9_diag_in", 10'd106, 9'd106, 12'hFFF);
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    probe("r10_sat_out", 10'd107, 9'd108, 12'h000);
    probe("bright_far", 10'd0, 9'd0, 12'hFFF);
    check("bright_busy", int'(busy), 0);

    do_event(1'b1, 1, 1'b0, 1'b0);
    do_event(1'b1, 2, 1'b0, 1'b0);
    do_event(1'b0, 2, 1'b1, 1'b1);
    do_event(1'b1, 3, 1'b0, 1'b0);
    do_event(1'b1, 0, 1'b0, 1'b1);

    // randomized traffic
    rcx = 10'd100;
    rcy = 9'd100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        rcx = 10'($urandom_range(20, 1000));
        rcy = 9'($urandom_range(20, 490));
      end
      cyc_rand(1'($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00,
               rcx, rcy);
    end

    // get to BRIGHT, then make sure the stage is non-zero before resetting
    for (int i = 0; i < 400; i++) begin
      if (busy == 1'b0) break;
      cyc_rand(1'b1, 2'b00, 10'd100, 9'd100);
    end
    check("pre_bright", int'(busy), 0);
    if (m_stage == 0) do_event(1'b1, 1, 1'b0, 1'b0);

    // async reset mid-CLOSING
    cyc(1'b0, 2'b11, 10'd100, 9'd100, 10'd100, 9'd100);
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    cyc(1'b1, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    check("closing_centre", int'(mask), 12'hFFF);
    check("closing_stage_nz", (stage != 2'd0) ? 1 : 0, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_mask", int'(mask), 12'h000);
    check("arst_grstn", int'(game_rstn), 0);
    check("arst_stage", int'(stage), 0);
    check("arst_busy", int'(busy), 1);
    model_reset();
    repeat (2) cyc(1'b0, 2'b00, 10'd100, 9'd100, 10'd100, 9'd100);
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc_rand(1'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 15) == 0) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00,
               10'd100, 9'd100);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
